// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default block-transfer widths for the cache/data_memory path.
// Used by mem_port_arbiter (optional ARB_ROUND_ROBIN_EN), the dcache and data_memory.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_AW = 28;
    localparam int unsigned MEM_DW = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for mem_port_arbiter.
// Fixed priority (index 0 highest) by default; rotating search when ARB_ROUND_ROBIN_EN is defined.
module arb_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0]   rr,
`endif
    output logic [IW-1:0]   winner,
    output logic            valid
);

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW:0] cand;

    // Search starts one past the last grantee and wraps modulo NREQ.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!valid && pending[cand[IW-1:0]]) begin
                valid  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid && pending[k]) begin
                valid  = 1'b1;
                winner = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data_memory block port among NREQ cache requesters with grant hold.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = MEM_AW,
    parameter int unsigned DW   = MEM_DW,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_read,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_address,
    input  logic [NREQ*DW-1:0] req_writedata,
    output logic [DW-1:0]    req_readdata,
    output logic [NREQ-1:0]  req_busywait,
    output logic             mem_read,
    output logic             mem_write,
    output logic [AW-1:0]    mem_address,
    output logic [DW-1:0]    mem_writedata,
    input  logic [DW-1:0]    mem_readdata,
    input  logic             mem_busywait,
    output logic [IW-1:0]    owner,
    output logic             idle
);

    arb_state_t      state;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] release_mask;
    logic [IW-1:0]   pick_winner;
    logic            pick_valid;
    logic [AW-1:0]   sel_address;
    logic [DW-1:0]   sel_writedata;
    logic            sel_write;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]   rr;
`endif

    assign pending      = req_read | req_write;
    assign req_readdata = mem_readdata;
    assign req_busywait = pending & ~release_mask;

    arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .pending (pending),
`ifdef ARB_ROUND_ROBIN_EN
        .rr      (rr),
`endif
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    // Only the owner is released, and only in the DONE cycle.
    always_comb begin
        release_mask = '0;
        if (state == ARB_DONE) begin
            release_mask[owner] = 1'b1;
        end
    end

    // Winner's payload; write takes precedence when both strobes are set.
    always_comb begin
        sel_address   = '0;
        sel_writedata = '0;
        sel_write     = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_winner == IW'(i)) begin
                sel_address   = req_address[i*AW +: AW];
                sel_writedata = req_writedata[i*DW +: DW];
                sel_write     = req_write[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ARB_IDLE;
            owner         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            idle          <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            rr            <= IW'(NREQ - 1);
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state         <= ARB_ISSUE;
                        idle          <= 1'b0;
                        owner         <= pick_winner;
                        mem_address   <= sel_address;
                        mem_writedata <= sel_writedata;
                        mem_write     <= sel_write;
                        mem_read      <= ~sel_write;
`ifdef ARB_ROUND_ROBIN_EN
                        rr            <= pick_winner;
`endif
                    end
                end
                ARB_ISSUE: begin
                    state <= ARB_WAIT;
                end
                // Memory cannot abort, so a withdrawn owner still runs to completion.
                ARB_WAIT: begin
                    if (!mem_busywait) begin
                        state     <= ARB_DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                    idle  <= 1'b1;
                end
                default: begin
                    state     <= ARB_IDLE;
                    idle      <= 1'b1;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a cycle-count transaction model.
// Build with or without ARB_ROUND_ROBIN_EN; expectations follow the macro.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = MEM_AW;
    localparam int unsigned DW   = MEM_DW;
    localparam int unsigned IW   = 2;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req_read;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_address;
    logic [NREQ*DW-1:0] req_writedata;
    logic [DW-1:0]      req_readdata;
    logic [NREQ-1:0]    req_busywait;
    logic               mem_read;
    logic               mem_write;
    logic [AW-1:0]      mem_address;
    logic [DW-1:0]      mem_writedata;
    logic [DW-1:0]      mem_readdata;
    logic               mem_busywait;
    logic [IW-1:0]      owner;
    logic               idle;

    mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_writedata (req_writedata),
        .req_readdata  (req_readdata),
        .req_busywait  (req_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .owner         (owner),
        .idle          (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
        return {a ^ 28'h5A5A5A5, 4'h1, ~a, 4'h2, a, 4'h3, a ^ 28'h0F0F0F0, 4'h4};
    endfunction

    // Memory: busy for lat cycles after the ISSUE cycle.
    int unsigned mem_cnt;
    int unsigned lat;
    always @(posedge clock or posedge reset) begin
        if (reset) mem_cnt <= 0;
        else if (mem_read || mem_write) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end
    assign mem_busywait = (mem_read || mem_write) && (mem_cnt < lat);
    assign mem_readdata = blk(mem_address);

    // Requester-side state
    logic          rq_rd   [NREQ];
    logic          rq_wr   [NREQ];
    logic [AW-1:0] rq_addr [NREQ];
    logic [DW-1:0] rq_data [NREQ];

    // Transaction model, in absolute cycle numbers
    int cyc, free_cycle, g, len, w, base_owner, rr_last, force_lat;
    bit tv, twr;
    logic [AW-1:0] taddr;
    logic [DW-1:0] tdata;
    int grant_log[$];
    int tests, errors;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] p);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= int'(NREQ); k++) begin
            int idx;
            idx = (rr_last + k) % int'(NREQ);
            if (p[idx]) return idx;
        end
`else
        for (int k = 0; k < int'(NREQ); k++) if (p[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] pend_vec();
        logic [NREQ-1:0] p;
        for (int i = 0; i < int'(NREQ); i++) p[i] = rq_rd[i] | rq_wr[i];
        return p;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_read[i]  = rq_rd[i];
            req_write[i] = rq_wr[i];
            req_address[i*AW +: AW]   = rq_addr[i];
            req_writedata[i*DW +: DW] = rq_data[i];
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] pend, exp_bw;
        bit exp_idle, active, done;
        int exp_owner;
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b0;
        apply_inputs();
        pend = pend_vec();
        exp_idle  = (cyc >= free_cycle);
        exp_owner = (tv && cyc > g) ? w : base_owner;
        if (exp_idle && pend != '0) begin
            base_owner = exp_owner;
            w     = model_pick(pend);
            twr   = rq_wr[w];
            taddr = rq_addr[w];
            tdata = rq_data[w];
            len   = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
            lat   = len;
            g     = cyc;
            tv    = 1'b1;
            free_cycle = cyc + len + 3;
            rr_last = w;
        end
        active = tv && cyc > g && cyc <= g + len + 1;
        done   = tv && cyc == g + len + 2;
        exp_bw = pend;
        if (done) exp_bw[w] = 1'b0;
        @(negedge clock);
        chk("idle", idle, exp_idle);
        chk("mem_read", mem_read, active && !twr);
        chk("mem_write", mem_write, active && twr);
        chk("owner", owner, exp_owner);
        chk("busywait", req_busywait, exp_bw);
        if (active || done) begin
            chk("mem_address", mem_address, taddr);
            chk("mem_writedata", mem_writedata, tdata);
        end
        if (done && !twr) chk("readdata", req_readdata, blk(taddr));
        if (tv && cyc == g + 1) grant_log.push_back(int'(owner));
        if (done) begin
            rq_rd[w] = 1'b0;
            rq_wr[w] = 1'b0;
        end
    endtask

    // Asserts reset partway through a cycle, checks its immediate effect, resets the model.
    task automatic do_reset();
        logic [NREQ-1:0] pend;
        @(posedge clock);
        #1;
        cyc++;
        apply_inputs();
        #1 reset = 1'b1;
        #1;
        pend = pend_vec();
        chk("rst_idle", idle, 1'b1);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_owner", owner, 0);
        chk("rst_busywait", req_busywait, pend);
        tv = 1'b0;
        base_owner = 0;
        rr_last = NREQ - 1;
        free_cycle = cyc + 1;
        @(negedge clock);
    endtask

    task automatic run_until_quiet(input int maxc);
        int n;
        n = 0;
        while ((pend_vec() != '0 || cyc + 1 < free_cycle) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) chk("quiet_timeout", 1, 0);
        step();
    endtask

    task automatic check_log(input string tag, input int exp[5], input int n);
        chk({tag, "_count"}, grant_log.size(), n);
        for (int k = 0; k < n && k < grant_log.size(); k++)
            chk($sformatf("%s_%0d", tag, k), grant_log[k], exp[k]);
    endtask

    initial begin
        int n;
        int exp_sim[5], exp_fair[5];
        tests = 0; errors = 0;
        reset = 1'b1;
        req_read = '0; req_write = '0; req_address = '0; req_writedata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rq_rd[i] = 1'b0; rq_wr[i] = 1'b0; rq_addr[i] = '0; rq_data[i] = '0;
        end
        cyc = 0; free_cycle = 0; tv = 1'b0; base_owner = 0; rr_last = NREQ - 1;
        force_lat = 0; lat = 1; g = 0; len = 0; w = 0;
        #1;
        chk("init_idle", idle, 1'b1);
        chk("init_mem_read", mem_read, 1'b0);
        chk("init_owner", owner, 0);
        chk("init_busywait", req_busywait, 0);

        // Single read, requester 2, latency 5
        rq_rd[2] = 1'b1; rq_addr[2] = 28'h0000123; rq_data[2] = {4{$urandom}};
        force_lat = 5;
        run_until_quiet(30);
        force_lat = 0;

        // Simultaneous 0 and 3, then 0 re-requests after its own grant completes
        do_reset();
        grant_log.delete();
        rq_rd[0] = 1'b1; rq_addr[0] = 28'h0000200; rq_data[0] = {4{$urandom}};
        rq_rd[3] = 1'b1; rq_addr[3] = 28'h0000300; rq_data[3] = {4{$urandom}};
        n = 0;
        while (rq_rd[0] && n < 40) begin step(); n++; end
        rq_rd[0] = 1'b1;
        run_until_quiet(60);
`ifdef ARB_ROUND_ROBIN_EN
        exp_sim = '{0, 3, 0, 0, 0};
`else
        exp_sim = '{0, 0, 3, 0, 0};
`endif
        check_log("simul", exp_sim, 3);

        // All four continuously pending
        do_reset();
        grant_log.delete();
        for (int i = 0; i < int'(NREQ); i++) begin
            rq_rd[i] = 1'b1; rq_addr[i] = AW'(32'h400 + i); rq_data[i] = {4{$urandom}};
        end
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            step();
            for (int i = 0; i < int'(NREQ); i++) if (!rq_rd[i]) rq_rd[i] = 1'b1;
            n++;
        end
        for (int i = 0; i < int'(NREQ); i++) rq_rd[i] = 1'b0;
        run_until_quiet(30);
`ifdef ARB_ROUND_ROBIN_EN
        exp_fair = '{0, 1, 2, 3, 0};
`else
        exp_fair = '{0, 0, 0, 0, 0};
`endif
        check_log("fair", exp_fair, 5);

        // Write by 1, read by 0 raised in the DONE cycle
        grant_log.delete();
        rq_wr[1] = 1'b1; rq_addr[1] = 28'h0000010;
        rq_data[1] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        step();
        n = 0;
        while (!(tv && cyc + 1 == g + len + 2) && n < 20) begin step(); n++; end
        rq_rd[0] = 1'b1; rq_addr[0] = 28'h0000040; rq_data[0] = {4{$urandom}};
        step();
        run_until_quiet(30);
        exp_sim = '{1, 0, 0, 0, 0};
        check_log("wr_rd", exp_sim, 2);

        // Reset during WAIT, then re-arbitration
        grant_log.delete();
        force_lat = 6;
        rq_rd[3] = 1'b1; rq_addr[3] = 28'h0ABCDEF; rq_data[3] = {4{$urandom}};
        repeat (4) step();
        do_reset();
        run_until_quiet(30);
        force_lat = 0;
        exp_sim = '{3, 3, 0, 0, 0};
        check_log("reset_wait", exp_sim, 2);

        // Owner withdraws during WAIT
        grant_log.delete();
        force_lat = 4;
        rq_rd[1] = 1'b1; rq_addr[1] = 28'h0000777; rq_data[1] = {4{$urandom}};
        repeat (3) step();
        rq_rd[1] = 1'b0;
        run_until_quiet(30);
        repeat (3) step();
        force_lat = 0;
        exp_sim = '{1, 0, 0, 0, 0};
        check_log("withdraw", exp_sim, 1);

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!rq_rd[i] && !rq_wr[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 1) rq_wr[i] = 1'b1;
                        else rq_rd[i] = 1'b1;
                        rq_addr[i] = AW'($urandom);
                        rq_data[i] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    rq_rd[i] = 1'b0;
                    rq_wr[i] = 1'b0;
                end
            end
            step();
        end
        for (int i = 0; i < int'(NREQ); i++) begin rq_rd[i] = 1'b0; rq_wr[i] = 1'b0; end
        run_until_quiet(30);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
